// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive path.
package uart_pkg;
  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;
  localparam logic X  = 1'bx;

  localparam int WORD_LEN    = 8;
  localparam int DEPTH_DEF   = 4;
  localparam int MIN_LOW_DEF = 32;
  localparam int STAT_W_DEF  = 8;

  typedef enum logic {
    a_IDLE  = 1'b0,
    a_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/u_rec_ctrl_if.sv
// Bus between the UART receiver/consumers and the receive controller.
interface u_rec_ctrl_if
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int STAT_W = STAT_W_DEF
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                rx_en;
  logic [WORD_LEN-1:0] rec_dataH;
  logic                rec_readyH;
  logic [1:0]          rd_req;
  logic                clr_stat;
  logic [1:0]          rd_gnt;
  logic [WORD_LEN-1:0] rd_data;
  logic                rd_valid;
  logic                rd_id;
  logic [CW-1:0]       fifo_count;
  logic                overrun_H;
  logic [STAT_W-1:0]   false_start_cnt;

  modport master (
    output rx_en, rec_dataH, rec_readyH, rd_req, clr_stat,
    input  rd_gnt, rd_data, rd_valid, rd_id, fifo_count, overrun_H, false_start_cnt
  );

  modport slave (
    input  rx_en, rec_dataH, rec_readyH, rd_req, clr_stat,
    output rd_gnt, rd_data, rd_valid, rd_id, fifo_count, overrun_H, false_start_cnt
  );
endinterface

// File: rtl/u_rx_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO only lands when a pop frees a slot.
module u_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_l,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WORD_LEN-1:0]     wdata_i,
  output logic [WORD_LEN-1:0]     rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WORD_LEN-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q;
  logic                do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/u_rec_ctrl.sv
// Receive controller: qualifies rec_readyH frames, buffers bytes, round-robin read arbiter.
//   state   | meaning
//   a_IDLE  | waiting for a non-empty FIFO and a read request
//   a_GRANT | one-hot grant to winner, FIFO pops this cycle
module u_rec_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int MIN_LOW = MIN_LOW_DEF,
  parameter int STAT_W  = STAT_W_DEF
) (
  input  logic   sys_clk,
  input  logic   sys_rst_l,
  u_rec_ctrl_if.slave rec_if
);
  localparam int LCW = $clog2(MIN_LOW + 1);
  localparam logic [LCW-1:0] MIN_LOW_C = LCW'(MIN_LOW);

  logic            prev_rdy_q;
  logic            armed_q, armed_d;
  logic [LCW-1:0]  low_cnt_q, low_cnt_d;
  logic            qual_rise, short_rise, capture;
  logic            fall, rise, rdy;

  logic               overrun_q;
  logic [STAT_W-1:0]  fs_cnt_q;

  arb_state_e          state_q, state_d;
  logic                winner_q, winner_d;
  logic                rr_q, rr_d;
  logic                pop;
  logic [1:0]          gnt;
  logic                rd_valid_q;
  logic [WORD_LEN-1:0] rd_data_q;
  logic                rd_id_q;

  logic [WORD_LEN-1:0]     fifo_rdata;
  logic                    fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_cnt;

  assign rdy  = rec_if.rec_readyH;
  assign fall = prev_rdy_q & ~rdy;
  assign rise = ~prev_rdy_q & rdy;

  always_comb begin
    armed_d    = armed_q;
    low_cnt_d  = low_cnt_q;
    qual_rise  = LO;
    short_rise = LO;
    if (fall) begin
      armed_d   = HI;
      low_cnt_d = LCW'(1);
    end else if (!rdy && armed_q) begin
      if (low_cnt_q < MIN_LOW_C) low_cnt_d = low_cnt_q + 1'b1;
    end else if (rise && armed_q) begin
      armed_d = LO;
      if (low_cnt_q >= MIN_LOW_C) qual_rise  = HI;
      else                        short_rise = HI;
    end
  end

  assign capture = qual_rise & rec_if.rx_en;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      prev_rdy_q <= LO;
      armed_q    <= LO;
      low_cnt_q  <= '0;
      overrun_q  <= LO;
      fs_cnt_q   <= '0;
    end else begin
      prev_rdy_q <= rdy;
      armed_q    <= armed_d;
      low_cnt_q  <= low_cnt_d;
      if (rec_if.clr_stat)                     overrun_q <= LO;
      else if (capture && fifo_full && !pop)   overrun_q <= HI;
      if (rec_if.clr_stat)                     fs_cnt_q <= '0;
      else if (short_rise && (fs_cnt_q != '1)) fs_cnt_q <= fs_cnt_q + 1'b1;
    end
  end

  u_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_l (sys_rst_l),
    .push_i    (capture),
    .pop_i     (pop),
    .wdata_i   (rec_if.rec_dataH),
    .rdata_o   (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_cnt)
  );

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    rr_d     = rr_q;
    pop      = LO;
    gnt      = 2'b00;
    case (state_q)
      a_IDLE: begin
        if (!fifo_empty && (rec_if.rd_req != 2'b00)) begin
          state_d  = a_GRANT;
          winner_d = rec_if.rd_req[rr_q] ? rr_q : ~rr_q;
        end
      end
      a_GRANT: begin
        gnt     = onehot2(winner_q);
        pop     = HI;
        rr_d    = ~winner_q;
        state_d = a_IDLE;
      end
      default: state_d = a_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state_q    <= a_IDLE;
      winner_q   <= LO;
      rr_q       <= LO;
      rd_valid_q <= LO;
      rd_data_q  <= '0;
      rd_id_q    <= LO;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      rr_q       <= rr_d;
      rd_valid_q <= pop;
      if (pop) begin
        rd_data_q <= fifo_rdata;
        rd_id_q   <= winner_q;
      end
    end
  end

  assign rec_if.rd_gnt          = gnt;
  assign rec_if.rd_data         = rd_data_q;
  assign rec_if.rd_valid        = rd_valid_q;
  assign rec_if.rd_id           = rd_id_q;
  assign rec_if.fifo_count      = fifo_cnt;
  assign rec_if.overrun_H       = overrun_q;
  assign rec_if.false_start_cnt = fs_cnt_q;
endmodule

// File: tb/tb_u_rec_ctrl.sv
// Bench for u_rec_ctrl: frame table plus scoreboard of expected read returns.
module tb_u_rec_ctrl;
  logic sys_clk = 1'b0;
  logic sys_rst_l;

  always #5 sys_clk = ~sys_clk;

  u_rec_ctrl_if #(.DEPTH(4), .STAT_W(8)) bus ();

  u_rec_ctrl #(.DEPTH(4), .MIN_LOW(32), .STAT_W(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_l (sys_rst_l),
    .rec_if    (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       id;
  } rd_exp_t;

  typedef struct {
    logic [7:0] data;
    int         low;
    logic       en;
    int         exp_cnt;
    int         exp_fs;
    int         exp_ovr;
  } vec_t;

  rd_exp_t exp_q[$];
  vec_t    vecs[8];
  int      checks = 0;
  int      errors = 0;
  logic [1:0] prev_gnt = 2'b00;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_rd(input logic [7:0] d, input logic id);
    rd_exp_t e;
    e.data = d;
    e.id   = id;
    exp_q.push_back(e);
  endtask

  always @(negedge sys_clk) begin
    if (!sys_rst_l) begin
      prev_gnt = 2'b00;
    end else begin
      if (bus.rd_gnt != 2'b00) chk("gnt_onehot", int'($onehot(bus.rd_gnt)), 1);
      if (bus.rd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got data %0h id %0d, expected no read", bus.rd_data, bus.rd_id);
        end else begin
          rd_exp_t e;
          e = exp_q.pop_front();
          chk("rd_data", bus.rd_data, e.data);
          chk("rd_id", bus.rd_id, e.id);
          chk("gnt_before_valid", prev_gnt, e.id ? 2'b10 : 2'b01);
        end
      end
      prev_gnt = bus.rd_gnt;
    end
  end

  task automatic send_frame(input logic [7:0] d, input int low, input logic en);
    @(posedge sys_clk); #1;
    bus.rec_readyH = 1'b0;
    bus.rec_dataH  = d;
    bus.rx_en      = en;
    repeat (low) @(posedge sys_clk);
    #1 bus.rec_readyH = 1'b1;
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (2) @(negedge sys_clk);
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge sys_clk); #1 sys_rst_l = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_l = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8'h77,  6, 1'b1, 0, 1, 0};
    vecs[1] = '{8'h3C, 40, 1'b1, 1, 1, 0};
    vecs[2] = '{8'h99, 31, 1'b1, 1, 2, 0};
    vecs[3] = '{8'h5A, 32, 1'b1, 2, 2, 0};
    vecs[4] = '{8'hEE, 50, 1'b0, 2, 2, 0};
    vecs[5] = '{8'h01, 33, 1'b1, 3, 2, 0};
    vecs[6] = '{8'h02, 33, 1'b1, 4, 2, 0};
    vecs[7] = '{8'h03, 33, 1'b1, 4, 2, 1};

    sys_rst_l      = 1'b0;
    bus.rx_en      = 1'b1;
    bus.rec_dataH  = 8'h00;
    bus.rec_readyH = 1'b0;
    bus.rd_req     = 2'b00;
    bus.clr_stat   = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_l = 1'b1;
    @(posedge sys_clk); #1 bus.rec_readyH = 1'b1;
    repeat (4) @(negedge sys_clk);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_fs", bus.false_start_cnt, 0);
    chk("rst_ovr", bus.overrun_H, 0);
    chk("rst_valid", bus.rd_valid, 0);
    chk("rst_gnt", bus.rd_gnt, 0);

    // Single byte to host; rr moves to 1 afterwards.
    bus.rd_req = 2'b01;
    exp_rd(8'hA5, 1'b0);
    send_frame(8'hA5, 160, 1'b1);
    wait_drain("drain_a5");
    bus.rd_req = 2'b00;
    chk("a5_count", bus.fifo_count, 0);

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].data, vecs[i].low, vecs[i].en);
      chk($sformatf("v%0d_count", i), bus.fifo_count, vecs[i].exp_cnt);
      chk($sformatf("v%0d_fs", i), bus.false_start_cnt, vecs[i].exp_fs);
      chk($sformatf("v%0d_ovr", i), bus.overrun_H, vecs[i].exp_ovr);
    end
    bus.rx_en = 1'b1;

    @(posedge sys_clk); #1 bus.clr_stat = 1'b1;
    @(posedge sys_clk); #1 bus.clr_stat = 1'b0;
    @(negedge sys_clk);
    chk("clr_ovr", bus.overrun_H, 0);
    chk("clr_fs", bus.false_start_cnt, 0);
    chk("clr_count", bus.fifo_count, 4);

    exp_rd(8'h3C, 1'b1);
    exp_rd(8'h5A, 1'b0);
    exp_rd(8'h01, 1'b1);
    exp_rd(8'h02, 1'b0);
    bus.rd_req = 2'b11;
    wait_drain("drain_table");
    bus.rd_req = 2'b00;
    chk("table_empty", bus.fifo_count, 0);

    send_frame(8'h44, 10, 1'b1);
    chk("pre_rst_fs", bus.false_start_cnt, 1);
    do_reset();
    repeat (3) @(negedge sys_clk);
    chk("post_rst_fs", bus.false_start_cnt, 0);

    // Both requesters active from reset: rr starts at 0.
    bus.rd_req = 2'b11;
    exp_rd(8'h11, 1'b0);
    exp_rd(8'h22, 1'b1);
    exp_rd(8'h33, 1'b0);
    send_frame(8'h11, 40, 1'b1);
    send_frame(8'h22, 40, 1'b1);
    send_frame(8'h33, 40, 1'b1);
    wait_drain("drain_rr");
    bus.rd_req = 2'b00;

    send_frame(8'hA1, 40, 1'b1);
    send_frame(8'hA2, 40, 1'b1);
    send_frame(8'hA3, 40, 1'b1);
    send_frame(8'hA4, 40, 1'b1);
    chk("full_count", bus.fifo_count, 4);

    // Rise lands in the grant cycle of a full FIFO; request dropped during grant.
    @(posedge sys_clk); #1;
    bus.rec_readyH = 1'b0;
    bus.rec_dataH  = 8'hB5;
    repeat (39) @(posedge sys_clk);
    #1 bus.rd_req = 2'b01;
    exp_rd(8'hA1, 1'b0);
    @(posedge sys_clk);
    #1;
    bus.rec_readyH = 1'b1;
    bus.rd_req     = 2'b00;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("pushpop_count", bus.fifo_count, 4);
    chk("pushpop_ovr", bus.overrun_H, 0);
    wait_drain("drain_pushpop");

    exp_rd(8'hA2, 1'b1);
    exp_rd(8'hA3, 1'b0);
    exp_rd(8'hA4, 1'b1);
    exp_rd(8'hB5, 1'b0);
    bus.rd_req = 2'b11;
    wait_drain("drain_full");
    bus.rd_req = 2'b00;

    send_frame(8'hC1, 40, 1'b1);
    chk("pre_midrst_count", bus.fifo_count, 1);
    @(posedge sys_clk); #1 bus.rec_readyH = 1'b0;
    repeat (20) @(posedge sys_clk);
    do_reset();
    repeat (20) @(posedge sys_clk);
    #1 bus.rec_readyH = 1'b1;
    repeat (4) @(negedge sys_clk);
    chk("midrst_count", bus.fifo_count, 0);
    chk("midrst_fs", bus.false_start_cnt, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end
endmodule
